uart_rx: RTL and testbench

- Serial receiver matching the team's 8N1 UART transmitter: 1 start bit (low), DATA_WIDTH data bits LSB first, 1 stop bit (high), idle high.
- Synchronises the asynchronous line, samples each bit at mid-period, and deserialises the word.
- Presents the word to the fabric on a valid/ready handshake.
- Flags framing errors (bad stop bit) and overruns (word lost because the previous one was not consumed).

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync.sv | 23 ++
 rtl/uart_rx.sv | 112 +++++++++++
 tb/tb_uart_rx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the bit-timing helpers
// that a matching transmitter can reuse.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_rx_state;

  function automatic int pulse_width(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int half_pulse_width(input int clk_freq, input int baud_rate);
    return pulse_width(clk_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for a single asynchronous input; runs every clock.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_reg <= RESET_VAL;
      q        <= RESET_VAL;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: mid-bit sampling, LSB-first deserialisation,
// valid/ready output with framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115_200,
  parameter int CLK_FREQ   = 50_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ena,
  input  logic                  rx_signal,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int PULSE_WIDTH      = pulse_width(CLK_FREQ, BAUD_RATE);
  localparam int HALF_PULSE_WIDTH = half_pulse_width(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W            = $clog2(PULSE_WIDTH) + 1;
  localparam int BIT_W            = $clog2(DATA_WIDTH);

  localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_PULSE_WIDTH - 1);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(DATA_WIDTH - 1);

  logic                  rx_s;
  uart_rx_state          state_reg;
  logic [CNT_W-1:0]      clk_cnt_reg;
  logic [BIT_W-1:0]      bit_cnt_reg;
  logic [DATA_WIDTH-1:0] shift_reg;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx_signal),
    .q       (rx_s)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      clk_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else if (ena) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // A delivery later in this block overrides this clear.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (!rx_s) begin
            clk_cnt_reg <= HALF_RELOAD;
            state_reg   <= START;
          end
        end
        START: begin
          if (clk_cnt_reg != '0) begin
            clk_cnt_reg <= clk_cnt_reg - CNT_W'(1);
          end else if (!rx_s) begin
            clk_cnt_reg <= FULL_RELOAD;
            bit_cnt_reg <= '0;
            state_reg   <= DATA;
          end else begin
            state_reg <= IDLE;
          end
        end
        DATA: begin
          if (clk_cnt_reg != '0) begin
            clk_cnt_reg <= clk_cnt_reg - CNT_W'(1);
          end else begin
            shift_reg   <= {rx_s, shift_reg[DATA_WIDTH-1:1]};
            clk_cnt_reg <= FULL_RELOAD;
            if (bit_cnt_reg == LAST_BIT) state_reg <= STOP;
            else bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
          end
        end
        STOP: begin
          if (clk_cnt_reg != '0) begin
            clk_cnt_reg <= clk_cnt_reg - CNT_W'(1);
          end else if (rx_s) begin
            // Back to IDLE mid-stop-bit so the next start edge is not missed.
            state_reg <= IDLE;
            if (!rx_valid || rx_ready) begin
              rx_data  <= shift_reg;
              rx_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            frame_err <= 1'b1;
            state_reg <= WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame table, corner-case sequences
// and randomised frame streams against a frame-level expectation model.
module tb_uart_rx;

  localparam int PW = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ena = 1'b1;
  logic       rx_signal = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  uart_rx #(
    .DATA_WIDTH (8),
    .BAUD_RATE  (100_000),
    .CLK_FREQ   (1_000_000)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ena       (ena),
    .rx_signal (rx_signal),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fe_cnt = 0, ovr_cnt = 0;
  int both_viol = 0, hold_viol = 0, freeze_viol = 0;
  int last_start_cyc = 0, valid_rise_cyc = 0;
  logic [7:0] got_q[$];
  logic       prev_valid = 1'b0, prev_acc = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Observer: samples 1 time unit before each rising edge.
  always begin
    @(negedge clk);
    #4;
    if (ena && rx_valid && rx_ready) got_q.push_back(rx_data);
    if (ena && frame_err) fe_cnt++;
    if (ena && overrun) ovr_cnt++;
    if (frame_err && overrun) both_viol++;
    if (rx_valid && !prev_valid) valid_rise_cyc = cyc;
    if (prev_valid && !prev_acc && rx_valid && rx_data !== prev_data) hold_viol++;
    prev_valid = rx_valid;
    prev_acc   = ena && rx_valid && rx_ready;
    prev_data  = rx_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    rx_signal = v;
    repeat (n) @(negedge clk);
  endtask

  // stop_low: cycles the line stays low from the start of a bad stop bit.
  task automatic send_frame(input logic [7:0] d, input bit stop_good, input int stop_low, input int gap);
    last_start_cyc = cyc;
    drive(1'b0, PW);
    for (int i = 0; i < 8; i++) drive(d[i], PW);
    if (stop_good) drive(1'b1, PW);
    else drive(1'b0, stop_low);
    drive(1'b1, gap);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_good;
    int         stop_low;
    int         gap;
    int         exp_words;
    logic [7:0] exp_data;
    int         exp_fe;
  } vec_t;

  vec_t       vecs[6];
  int         fe0, ov0, nbad, lat;
  logic [7:0] d, first;
  bit         good;
  logic [7:0] exp_q[$];

  initial begin
    vecs[0] = '{data:8'hA5, stop_good:1'b1, stop_low:0,  gap:20, exp_words:1, exp_data:8'hA5, exp_fe:0};
    vecs[1] = '{data:8'h81, stop_good:1'b0, stop_low:30, gap:20, exp_words:0, exp_data:8'h00, exp_fe:1};
    vecs[2] = '{data:8'h55, stop_good:1'b1, stop_low:0,  gap:20, exp_words:1, exp_data:8'h55, exp_fe:0};
    vecs[3] = '{data:8'h00, stop_good:1'b1, stop_low:0,  gap:20, exp_words:1, exp_data:8'h00, exp_fe:0};
    vecs[4] = '{data:8'hFF, stop_good:1'b1, stop_low:0,  gap:20, exp_words:1, exp_data:8'hFF, exp_fe:0};
    vecs[5] = '{data:8'h5A, stop_good:1'b1, stop_low:0,  gap:20, exp_words:1, exp_data:8'h5A, exp_fe:0};

    // Reset state.
    repeat (4) @(negedge clk);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    reset_n = 1'b1;
    drive(1'b1, 10);

    // Directed frame table, consumer always ready.
    rx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      got_q.delete();
      fe0 = fe_cnt;
      ov0 = ovr_cnt;
      send_frame(vecs[i].data, vecs[i].stop_good, vecs[i].stop_low, vecs[i].gap);
      check($sformatf("vec%0d_words", i), got_q.size(), vecs[i].exp_words);
      if (vecs[i].exp_words > 0) begin
        check($sformatf("vec%0d_data", i), got_q.size() > 0 ? got_q[0] : 8'hxx, vecs[i].exp_data);
        lat = valid_rise_cyc - last_start_cyc;
        check($sformatf("vec%0d_latency_%0d_in_97_99", i, lat), (lat >= 97 && lat <= 99), 1);
      end
      check($sformatf("vec%0d_frame_err", i), fe_cnt - fe0, vecs[i].exp_fe);
      check($sformatf("vec%0d_overrun", i), ovr_cnt - ov0, 0);
      check($sformatf("vec%0d_valid_idle", i), rx_valid, 0);
    end

    // Start-bit glitch, then a 0x00 frame.
    got_q.delete();
    fe0 = fe_cnt;
    drive(1'b0, 3);
    drive(1'b1, 30);
    check("glitch_words", got_q.size(), 0);
    check("glitch_frame_err", fe_cnt - fe0, 0);
    send_frame(8'h00, 1'b1, 0, 20);
    check("after_glitch_words", got_q.size(), 1);
    check("after_glitch_data", got_q.size() > 0 ? got_q[0] : 8'hxx, 8'h00);

    // Break: line held low for 200 cycles, then 0xFF.
    got_q.delete();
    fe0 = fe_cnt;
    drive(1'b0, 200);
    drive(1'b1, 30);
    check("break_frame_err", fe_cnt - fe0, 1);
    check("break_words", got_q.size(), 0);
    send_frame(8'hFF, 1'b1, 0, 20);
    check("after_break_data", got_q.size() == 1 ? got_q[0] : 8'hxx, 8'hFF);

    // Overrun: 0x3C then 0xC3 back-to-back with the consumer stalled.
    got_q.delete();
    ov0 = ovr_cnt;
    rx_ready = 1'b0;
    send_frame(8'h3C, 1'b1, 0, 0);
    send_frame(8'hC3, 1'b1, 0, 20);
    check("ovr_count", ovr_cnt - ov0, 1);
    check("ovr_valid", rx_valid, 1);
    check("ovr_data", rx_data, 8'h3C);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("ovr_accept_clears", rx_valid, 0);
    check("ovr_accepted", got_q.size() == 1 ? got_q[0] : 8'hxx, 8'h3C);

    // Freeze with ena=0 mid-frame, then reset mid-frame.
    got_q.delete();
    fe0 = fe_cnt;
    ov0 = ovr_cnt;
    send_frame(8'h66, 1'b1, 0, 20);
    check("pre_freeze_valid", rx_valid, 1);
    check("pre_freeze_data", rx_data, 8'h66);
    fork
      send_frame(8'hFF, 1'b1, 0, 20);
      begin
        repeat (30) @(negedge clk);
        ena = 1'b0;
        rx_ready = 1'b1;
        repeat (50) begin
          @(negedge clk);
          if (rx_valid !== 1'b1 || rx_data !== 8'h66 || frame_err || overrun) freeze_viol++;
        end
        ena = 1'b1;
        rx_ready = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("midreset_valid", rx_valid, 0);
        check("midreset_data", rx_data, 0);
      end
    join
    check("freeze_words", got_q.size(), 0);
    check("freeze_frame_err", fe_cnt - fe0, 0);
    check("freeze_overrun", ovr_cnt - ov0, 0);
    rx_ready = 1'b1;
    send_frame(8'h5A, 1'b1, 0, 20);
    check("after_reset_data", got_q.size() == 1 ? got_q[0] : 8'hxx, 8'h5A);

    // Random stream, consumer ready: every good frame delivered in order.
    got_q.delete();
    exp_q.delete();
    fe0 = fe_cnt;
    ov0 = ovr_cnt;
    nbad = 0;
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 3) != 0);
      if (good) begin
        exp_q.push_back(d);
        send_frame(d, 1'b1, 0, $urandom_range(0, 15));
      end else begin
        nbad++;
        send_frame(d, 1'b0, $urandom_range(10, 25), $urandom_range(10, 25));
      end
    end
    drive(1'b1, 30);
    check("rand_words", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("rand_word%0d", i), i < got_q.size() ? got_q[i] : 8'hxx, exp_q[i]);
    check("rand_frame_err", fe_cnt - fe0, nbad);
    check("rand_overrun", ovr_cnt - ov0, 0);

    // Random stream, consumer stalled: first word held, the rest overrun.
    got_q.delete();
    fe0 = fe_cnt;
    ov0 = ovr_cnt;
    rx_ready = 1'b0;
    first = 8'h00;
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      if (i == 0) first = d;
      send_frame(d, 1'b1, 0, $urandom_range(0, 10));
    end
    drive(1'b1, 20);
    check("stall_valid", rx_valid, 1);
    check("stall_data", rx_data, first);
    check("stall_overrun", ovr_cnt - ov0, 3);
    check("stall_frame_err", fe_cnt - fe0, 0);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("stall_accept_clears", rx_valid, 0);
    check("stall_accepted", got_q.size() == 1 ? got_q[0] : 8'hxx, first);

    // Whole-run invariants.
    check("fe_and_ovr_same_cycle", both_viol, 0);
    check("data_changed_while_valid", hold_viol, 0);
    check("outputs_moved_while_disabled", freeze_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
